// File: rtl/divmod_seq.sv
// Sequential restoring divider: SPC shift/subtract stages per clock, valid/ready on both sides.
// Define DIVMOD_SEQ_SIGNED_EN to add signed operation (magnitude load + FIX sign correction).
module divmod_seq #(
  parameter int WIDTH = 32,
  parameter int SPC   = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int STEPS = WIDTH / SPC;
  localparam int CW    = $clog2(STEPS + 1);

`ifdef DIVMOD_SEQ_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, q_reg, r_reg;
  logic [CW-1:0]    cnt_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             div_zero_reg, out_valid_reg;
  logic [WIDTH-1:0] res_q, res_r;
  logic [WIDTH-1:0] load_q, load_b;
  logic             load_out;

`ifdef DIVMOD_SEQ_SIGNED_EN
  logic sgn_reg, a_neg_reg, b_neg_reg;
  logic a_neg_in, b_neg_in;
  assign a_neg_in = sgn & dividend[WIDTH-1];
  assign b_neg_in = sgn & divisor[WIDTH-1];
  // Magnitudes feed the unsigned core; |MIN| stays MIN, which is the correct unsigned value.
  assign load_q   = a_neg_in ? (~dividend + 1'b1) : dividend;
  assign load_b   = b_neg_in ? (~divisor + 1'b1) : divisor;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign load_q     = dividend;
  assign load_b     = divisor;
`endif

  // Combinational chain of SPC restoring stages; remainder is widened by one bit for the trial compare.
  genvar gi;
  generate
    for (gi = 0; gi < SPC; gi++) begin : g_stage
      logic [WIDTH-1:0] r_in, q_in, r_out, q_out;
      logic [WIDTH:0]   shifted;
      logic             borrow;
      if (gi == 0) begin : g_first
        assign r_in = r_reg;
        assign q_in = q_reg;
      end else begin : g_next
        assign r_in = g_stage[gi-1].r_out;
        assign q_in = g_stage[gi-1].q_out;
      end
      assign shifted = {r_in, q_in[WIDTH-1]};
      assign borrow  = shifted < {1'b0, b_reg};
      assign r_out   = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - b_reg);
      assign q_out   = {q_in[WIDTH-2:0], ~borrow};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    res_q      = q_reg;
    res_r      = r_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = CALC;
      CALC: begin
        // cnt==0 is the write-back cycle after the last stage group.
        if (cnt_reg == '0) begin
          if (dz_reg) begin
            res_q      = '1;
            res_r      = a_reg;
            state_next = DONE;
          end else begin
`ifdef DIVMOD_SEQ_SIGNED_EN
            state_next = sgn_reg ? FIX : DONE;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef DIVMOD_SEQ_SIGNED_EN
      FIX: begin
        res_q      = (a_neg_reg ^ b_neg_reg) ? (~q_reg + 1'b1) : q_reg;
        res_r      = a_neg_reg ? (~r_reg + 1'b1) : r_reg;
        state_next = DONE;
      end
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load_out = (state_reg != DONE) && (state_next == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef DIVMOD_SEQ_SIGNED_EN
      sgn_reg       <= 1'b0;
      a_neg_reg     <= 1'b0;
      b_neg_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        a_reg   <= dividend;
        b_reg   <= load_b;
        q_reg   <= load_q;
        r_reg   <= '0;
        dz_reg  <= (divisor == '0);
        cnt_reg <= (divisor == '0) ? '0 : CW'(STEPS);
`ifdef DIVMOD_SEQ_SIGNED_EN
        sgn_reg   <= sgn;
        a_neg_reg <= a_neg_in;
        b_neg_reg <= b_neg_in;
`endif
      end else if (state_reg == CALC && cnt_reg != '0) begin
        q_reg   <= g_stage[SPC-1].q_out;
        r_reg   <= g_stage[SPC-1].r_out;
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (load_out) begin
        quotient_reg  <= res_q;
        remainder_reg <= res_r;
        div_zero_reg  <= dz_reg;
      end
      out_valid_reg <= (state_next == DONE);
    end
  end

  assign in_ready  = reset_n & (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divmod_seq.sv
// Directed-vector bench for divmod_seq: WIDTH=8 with SPC=1 and SPC=4, plus a WIDTH=32 random run.
// Signed vectors are added when DIVMOD_SEQ_SIGNED_EN is defined.
module tb_divmod_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        in_valid [3];
  logic        out_ready[3];
  logic        sgn      [3];
  logic [31:0] a_in     [3];
  logic [31:0] b_in     [3];
  logic        in_ready_w [3];
  logic        out_valid_w[3];
  logic        dz_w       [3];
  logic [31:0] q_w        [3];
  logic [31:0] r_w        [3];
  logic [7:0]  q0, r0, q1, r1;

  int checks = 0;
  int errors = 0;
  int steps[3] = '{8, 2, 16};

  divmod_seq #(.WIDTH(8), .SPC(1)) u_spc1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .dividend(a_in[0][7:0]), .divisor(b_in[0][7:0]), .sgn(sgn[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .quotient(q0), .remainder(r0), .div_zero(dz_w[0]));

  divmod_seq #(.WIDTH(8), .SPC(4)) u_spc4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .dividend(a_in[1][7:0]), .divisor(b_in[1][7:0]), .sgn(sgn[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .quotient(q1), .remainder(r1), .div_zero(dz_w[1]));

  divmod_seq #(.WIDTH(32), .SPC(2)) u_w32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .dividend(a_in[2]), .divisor(b_in[2]), .sgn(sgn[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .quotient(q_w[2]), .remainder(r_w[2]), .div_zero(dz_w[2]));

  assign q_w[0] = {24'b0, q0};
  assign r_w[0] = {24'b0, r0};
  assign q_w[1] = {24'b0, q1};
  assign r_w[1] = {24'b0, r1};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  // mode 0: take result at once; 1: random out_ready stalls; 2: hold out_ready low 5 cycles
  task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] bv, input logic s,
                       input int mode, output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int lat);
    int   n;
    logic hs;
    logic busy_ok;
    logic stable_ok;
    n = 0;
    while (!in_ready_w[d] && n < 50) begin
      @(posedge clock); #1; n++;
    end
    a_in[d] = av; b_in[d] = bv; sgn[d] = s; in_valid[d] = 1'b1;
    @(posedge clock); #1;
    in_valid[d] = 1'b0;
    busy_ok = 1'b1;
    lat = 0;
    while (!out_valid_w[d] && lat < 100) begin
      if (in_ready_w[d]) busy_ok = 1'b0;
      @(posedge clock); #1; lat++;
    end
    if (in_ready_w[d]) busy_ok = 1'b0;
    q = q_w[d]; r = r_w[d]; dz = dz_w[d];
    chk("in_ready_busy", d, 32'(busy_ok), 32'd1);
    if (mode == 2) begin
      for (int k = 0; k < 5; k++) begin
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b1;
        a_in[d] = ~av; b_in[d] = 32'd1;
        @(posedge clock); #1;
        chk("hold_valid", d, 32'(out_valid_w[d]), 32'd1);
        chk("hold_q", d, q_w[d], q);
        chk("hold_r", d, r_w[d], r);
      end
      in_valid[d] = 1'b0;
    end
    stable_ok = 1'b1;
    n = 0;
    do begin
      hs = (mode == 1 && n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready[d] = hs;
      if (q_w[d] !== q || r_w[d] !== r || out_valid_w[d] !== 1'b1) stable_ok = 1'b0;
      @(posedge clock); #1; n++;
    end while (!hs);
    out_ready[d] = 1'b0;
    chk("stall_stable", d, 32'(stable_ok), 32'd1);
    chk("out_valid_clear", d, 32'(out_valid_w[d]), 32'd0);
    chk("in_ready_after", d, 32'(in_ready_w[d]), 32'd1);
    $display("op dut%0d a=%0h b=%0h s=%0b -> q=%0h r=%0h dz=%0b lat=%0d", d, av, bv, s, q, r, dz, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, eq, er;
    logic        dz, flag;
    int          lat;

    vecs.push_back('{32'd100,  32'd7,   1'b0, 32'd14,  32'd2,   1'b0});
    vecs.push_back('{32'd255,  32'd1,   1'b0, 32'd255, 32'd0,   1'b0});
    vecs.push_back('{32'd3,    32'd200, 1'b0, 32'd0,   32'd3,   1'b0});
    vecs.push_back('{32'h5A,   32'd0,   1'b0, 32'hFF,  32'h5A,  1'b1});
    vecs.push_back('{32'd20,   32'd3,   1'b0, 32'd6,   32'd2,   1'b0});
    vecs.push_back('{32'd0,    32'd5,   1'b0, 32'd0,   32'd0,   1'b0});
    vecs.push_back('{32'd200,  32'd200, 1'b0, 32'd1,   32'd0,   1'b0});
    vecs.push_back('{32'd254,  32'd127, 1'b0, 32'd2,   32'd0,   1'b0});
    vecs.push_back('{32'd250,  32'd129, 1'b0, 32'd1,   32'd121, 1'b0});
`ifdef DIVMOD_SEQ_SIGNED_EN
    vecs.push_back('{32'hF9,   32'd2,   1'b1, 32'hFD,  32'hFF,  1'b0});
    vecs.push_back('{32'd7,    32'hFE,  1'b1, 32'hFD,  32'd1,   1'b0});
    vecs.push_back('{32'h80,   32'hFF,  1'b1, 32'h80,  32'd0,   1'b0});
    vecs.push_back('{32'hF9,   32'd0,   1'b1, 32'hFF,  32'hF9,  1'b1});
`endif

    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; sgn[d] = 1'b0; a_in[d] = '0; b_in[d] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, 32'(in_ready_w[d]), 32'd0);
      chk("rst_out_valid", d, 32'(out_valid_w[d]), 32'd0);
      chk("rst_quotient", d, q_w[d], 32'd0);
      chk("rst_remainder", d, r_w[d], 32'd0);
      chk("rst_div_zero", d, 32'(dz_w[d]), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("in_ready_release", 0, 32'(in_ready_w[0]), 32'd1);
    @(posedge clock); #1;

    for (int d = 0; d < 2; d++) begin
      foreach (vecs[i]) begin
        do_op(d, vecs[i].a, vecs[i].b, vecs[i].s, 0, q, r, dz, lat);
        chk("quotient", d, q, vecs[i].q);
        chk("remainder", d, r, vecs[i].r);
        chk("div_zero", d, 32'(dz), 32'(vecs[i].dz));
        chk("latency", d, 32'(lat), vecs[i].dz ? 32'd1 : 32'(steps[d] + 1 + (vecs[i].s ? 1 : 0)));
      end
    end

    // Result held while the sink stalls for five cycles.
    do_op(0, 32'd100, 32'd7, 1'b0, 2, q, r, dz, lat);
    chk("hold_quotient", 0, q, 32'd14);
    chk("hold_remainder", 0, r, 32'd2);

    // Reset in the middle of a computation aborts it without a result.
    a_in[0] = 32'd100; b_in[0] = 32'd7; in_valid[0] = 1'b1;
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 0, 32'(out_valid_w[0]), 32'd0);
    chk("abort_in_ready", 0, 32'(in_ready_w[0]), 32'd0);
    chk("abort_quotient", 0, q_w[0], 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("abort_release_ready", 0, 32'(in_ready_w[0]), 32'd1);
    flag = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (out_valid_w[0]) flag = 1'b1;
    end
    chk("abort_no_result", 0, 32'(flag), 32'd0);
    do_op(0, 32'd20, 32'd3, 1'b0, 0, q, r, dz, lat);
    chk("post_abort_q", 0, q, 32'd6);
    chk("post_abort_r", 0, r, 32'd2);
    chk("post_abort_lat", 0, 32'(lat), 32'd9);

    // 32-bit unsigned random run with idle gaps and output stalls.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] av, bv;
      av = $urandom;
      case ($urandom_range(0, 7))
        0:       bv = 32'd0;
        1, 2:    bv = $urandom_range(1, 255);
        3:       bv = av >> $urandom_range(0, 31);
        default: bv = $urandom;
      endcase
      if (bv == 32'd0) begin
        eq = 32'hFFFF_FFFF; er = av;
      end else begin
        eq = av / bv; er = av % bv;
      end
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      do_op(2, av, bv, 1'b0, 1, q, r, dz, lat);
      chk("rand_quotient", 2, q, eq);
      chk("rand_remainder", 2, r, er);
      chk("rand_div_zero", 2, 32'(dz), 32'(bv == 32'd0));
      chk("rand_latency", 2, 32'(lat), (bv == 32'd0) ? 32'd1 : 32'd17);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
